// File: rtl/muldiv_seq_unit.sv
// Sequential WIDTH-generic multiply/divide unit (MULT, MULTU, DIV, DIVU) with a start/busy/done handshake.
// Optional: define MULDIV_EARLY_TERM_EN to let multiplies finish once the remaining multiplier is zero.
module muldiv_seq_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_reg;
  logic                 is_div_reg;
  logic                 neg_lo_reg;
  logic                 neg_hi_reg;
  logic [2*WIDTH-1:0]   opnd_reg;    // shifted multiplicand, or divisor in the low half
  logic [2*WIDTH-1:0]   acc_reg;     // product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]     mplier_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic                 signed_op;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 b_zero;
  logic [2*WIDTH-1:0]   mul_sum;
  logic [WIDTH-1:0]     mplier_next;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic                 last_iter;
  logic                 calc_exit;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     fix_hi;
  logic [WIDTH-1:0]     fix_lo;

  always_comb begin
    signed_op   = ~op[0];
    a_neg       = signed_op & a[WIDTH-1];
    b_neg       = signed_op & b[WIDTH-1];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    b_zero      = (b == '0);

    // Multiplicand is shifted left instead of shifting the accumulator right,
    // so stopping early never leaves the product misaligned.
    mul_sum     = acc_reg + (mplier_reg[0] ? opnd_reg : '0);
    mplier_next = mplier_reg >> 1;

    rem_shift   = acc_reg[2*WIDTH-1:WIDTH-1];
    div_ge      = rem_shift >= {1'b0, opnd_reg[WIDTH-1:0]};
    rem_sub     = rem_shift[WIDTH-1:0] - opnd_reg[WIDTH-1:0];
    div_next    = {(div_ge ? rem_sub : rem_shift[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};

    last_iter   = (cnt_reg == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_TERM_EN
    calc_exit   = last_iter | (!is_div_reg && (mplier_next == '0));
`else
    calc_exit   = last_iter;
`endif

    prod_fix    = neg_lo_reg ? -acc_reg : acc_reg;
    fix_hi      = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo      = prod_fix[WIDTH-1:0];
    if (is_div_reg) begin
      fix_lo = neg_lo_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
      fix_hi = neg_hi_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      is_div_reg <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      opnd_reg   <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            is_div_reg <= op[1];
            cnt_reg    <= '0;
            div_zero   <= 1'b0;
            busy       <= 1'b1;
            neg_lo_reg <= a_neg ^ b_neg;
            neg_hi_reg <= op[1] & a_neg;
            state_reg  <= CALC;
            if (op[1]) begin
              opnd_reg <= {{WIDTH{1'b0}}, b_mag};
              acc_reg  <= {{WIDTH{1'b0}}, a_mag};
              if (b_zero) begin
                // Preload the divide-by-zero answer; FIX passes it through uncorrected.
                acc_reg    <= {a, {WIDTH{1'b1}}};
                neg_lo_reg <= 1'b0;
                neg_hi_reg <= 1'b0;
                div_zero   <= 1'b1;
                state_reg  <= FIX;
              end
            end else begin
              opnd_reg   <= {{WIDTH{1'b0}}, a_mag};
              mplier_reg <= b_mag;
              acc_reg    <= '0;
            end
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (is_div_reg) begin
            acc_reg <= div_next;
          end else begin
            acc_reg    <= mul_sum;
            opnd_reg   <= opnd_reg << 1;
            mplier_reg <= mplier_next;
          end
          if (calc_exit) state_reg <= FIX;
        end
        FIX: begin
          hi        <= fix_hi;
          lo        <= fix_lo;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
